cache_line_axi_reader: RTL and testbench

Line-fill read master between the complex cache's miss path and the AXI4 memory port (in simulation, the AXI VIP slave memory holding the instruction or data image). It accepts one line-fill request at a time and aligns the address to a line boundary. It issues a single INCR burst of LINE_WORDS beats, assembles the returned words into a line, and hands the line back to the cache with an error flag.

---
 rtl/kuuga_cache_pkg.sv | 24 ++
 rtl/cache_line_axi_reader.sv | 119 +++++++++++
 tb/tb_cache_line_axi_reader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/kuuga_cache_pkg.sv
// Shared cache-side types and AXI4 read-channel encodings.
package kuuga_cache_pkg;

    localparam int KC_LINE_WORDS = 4;

    typedef logic [KC_LINE_WORDS-1:0][31:0] line_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [3:0] AXI_CACHE_NORM = 4'b0011;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_ADDR,
        FS_DATA,
        FS_RESP
    } fill_state_t;

endpackage

// File: rtl/cache_line_axi_reader.sv
// Line-fill AXI4 read master: one aligned INCR burst per miss, assembled
// into a full line and returned with a sticky error flag.
module cache_line_axi_reader
    import kuuga_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [ADDR_WIDTH-1:0]            req_addr_i,
    output logic                             resp_valid_o,
    input  logic                             resp_ready_i,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_data_o,
    output logic                             resp_error_o,
    output logic                             m_axi_arid,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic [2:0]                       m_axi_arprot,
    output logic [3:0]                       m_axi_arcache,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic                             m_axi_rid,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                       m_axi_rresp,
    input  logic                             m_axi_rlast,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);

    fill_state_t state, state_next;

    logic [BEAT_W-1:0]                    beat_cnt;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line;
    logic [ADDR_WIDTH-1:0]                line_addr;
    logic                                 err;
    logic                                 req_ready, arvalid, rready, resp_valid;

    logic accept, ar_done, beat, final_beat, beat_err;

    // Single ID, one burst in flight: rid carries no information.
    logic unused_rid;
    assign unused_rid = m_axi_rid;

    assign accept     = req_valid_i && req_ready;
    assign ar_done    = arvalid && m_axi_arready;
    assign beat       = rready && m_axi_rvalid;
    assign final_beat = (beat_cnt == BEAT_W'(LINE_WORDS - 1));
    // RLAST must appear on exactly the last beat; a mismatch either way is a fault.
    assign beat_err   = (m_axi_rresp == AXI_RESP_SLVERR) || (m_axi_rresp == AXI_RESP_DECERR)
                     || (m_axi_rlast != final_beat);

    always_comb begin
        state_next = state;
        case (state)
            FS_IDLE: if (accept)                     state_next = FS_ADDR;
            FS_ADDR: if (ar_done)                    state_next = FS_DATA;
            FS_DATA: if (beat && final_beat)         state_next = FS_RESP;
            FS_RESP: if (resp_valid && resp_ready_i) state_next = FS_IDLE;
            default:                                 state_next = FS_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so no input reaches an output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FS_IDLE;
            req_ready  <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            resp_valid <= 1'b0;
            beat_cnt   <= '0;
            line       <= '0;
            line_addr  <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            req_ready  <= (state_next == FS_IDLE);
            arvalid    <= (state_next == FS_ADDR);
            rready     <= (state_next == FS_DATA);
            resp_valid <= (state_next == FS_RESP);
            if (accept) begin
                line_addr <= {req_addr_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                beat_cnt  <= '0;
                err       <= 1'b0;
            end
            if (beat) begin
                line[beat_cnt] <= m_axi_rdata;
                beat_cnt       <= beat_cnt + 1'b1;
                if (beat_err) err <= 1'b1;
            end
        end
    end

    assign req_ready_o   = req_ready;
    assign resp_valid_o  = resp_valid;
    assign resp_data_o   = line;
    assign resp_error_o  = err;

    assign m_axi_arid    = 1'(AXI_ID);
    assign m_axi_araddr  = line_addr;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arcache = AXI_CACHE_NORM;
    assign m_axi_arvalid = arvalid;
    assign m_axi_rready  = rready;

endmodule

// File: tb/tb_cache_line_axi_reader.sv
// Directed bench for cache_line_axi_reader with an inline AXI read-slave model.
module tb_cache_line_axi_reader;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_ready;
    logic [31:0]   req_addr = '0;
    logic          resp_valid, resp_ready = 1'b0, resp_error;
    logic [127:0]  resp_data;
    logic          arid, arvalid, arready = 1'b0;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize, arprot;
    logic [1:0]    arburst;
    logic [3:0]    arcache;
    logic          rid = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready;
    logic [31:0]   rdata = '0;
    logic [1:0]    rresp = '0;

    int checks = 0, errors = 0, cyc = 0, t0 = 0;

    cache_line_axi_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(LW), .AXI_ID(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_error_o(resp_error),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arprot(arprot),
        .m_axi_arcache(arcache), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Memory image: word at 0x100 holds 0x1000, one increment per word.
    function automatic logic [31:0] img(input logic [31:0] a);
        return 32'h1000 + (a >> 2) - 32'h40;
    endfunction

    task automatic do_req(input logic [31:0] a);
        int t = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && t < 50) begin tick; t++; end
        chk("req_ready", req_ready, 1);
        t0 = cyc;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic serve(input logic [31:0] ea, input int ar_dly, input int gap,
                         input int err_beat, input int early_last, input int no_last,
                         input int nbeats);
        int t = 0;
        while (!arvalid && t < 50) begin tick; t++; end
        chk("ar_seen", arvalid, 1);
        chk("araddr", araddr, ea);
        chk("arlen", arlen, 8'd3);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
        chk("arid_prot_cache", {arid, arprot, arcache}, {1'b0, 3'b000, 4'b0011});
        for (int i = 0; i < ar_dly; i++) begin
            tick;
            chk("ar_hold", {arvalid, araddr, arlen}, {1'b1, ea, 8'd3});
            chk("ar_rready_lo", rready, 0);
        end
        arready = 1'b1;
        tick;
        arready = 1'b0;
        chk("ar_drop", arvalid, 0);
        for (int b = 0; b < nbeats; b++) begin
            if (gap > 0 && (b % 2) == 0)
                for (int g = 0; g < gap; g++) tick;
            rvalid = 1'b1;
            rdata  = img(ea + 32'(4 * b));
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == LW - 1) ? (no_last == 0) : (b == early_last);
            t = 0;
            while (!rready && t < 50) begin tick; t++; end
            chk("rready", rready, 1);
            tick;
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
        if (nbeats == LW) chk("rready_off", rready, 0);
    endtask

    task automatic finish_resp(input logic [127:0] exp, input logic ee, input int hold);
        int t = 0;
        while (!resp_valid && t < 50) begin tick; t++; end
        chk("resp_valid", resp_valid, 1);
        chk("resp_data", resp_data, exp);
        chk("resp_err", resp_error, ee);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk("resp_hold_vr", {resp_valid, req_ready}, 2'b10);
            chk("resp_hold_d", resp_data, exp);
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        chk("resp_done", {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_flags", {req_ready, resp_valid, resp_error, arvalid, rready}, 5'b0);
        chk("rst_data", resp_data, 128'h0);
        chk("rst_araddr", araddr, 32'h0);
        rst = 1'b0;
        tick;
        chk("post_rst_ready", req_ready, 1);

        // Basic fill with minimum latency
        do_req(32'h10C);
        serve(32'h100, 0, 0, -1, -1, 0, LW);
        chk("latency", 32'(cyc - t0), 32'd6);
        finish_resp(128'h00001003_00001002_00001001_00001000, 1'b0, 0);

        // Backpressure on AR, R and response
        do_req(32'h204);
        serve(32'h200, 5, 2, -1, -1, 0, LW);
        finish_resp(128'h00001043_00001042_00001041_00001040, 1'b0, 4);

        // SLVERR on beat 2
        do_req(32'h300);
        serve(32'h300, 0, 0, 2, -1, 0, LW);
        finish_resp(128'h00001083_00001082_00001081_00001080, 1'b1, 0);

        // Error clears on the next request
        do_req(32'h10C);
        chk("err_clr", resp_error, 0);
        serve(32'h100, 0, 0, -1, -1, 0, LW);
        finish_resp(128'h00001003_00001002_00001001_00001000, 1'b0, 0);

        // Early RLAST on beat 1, then RLAST missing on beat 3
        do_req(32'h108);
        serve(32'h100, 0, 0, -1, 1, 0, LW);
        finish_resp(128'h00001003_00001002_00001001_00001000, 1'b1, 0);
        do_req(32'h104);
        serve(32'h100, 0, 0, -1, -1, 1, LW);
        finish_resp(128'h00001003_00001002_00001001_00001000, 1'b1, 0);

        // Back-to-back with req_valid held
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick;
        req_addr  = 32'h12B0;
        serve(32'h0, 0, 0, -1, -1, 0, LW);
        chk("b2b_d0", resp_data, 128'h00000FC3_00000FC2_00000FC1_00000FC0);
        chk("b2b_vld0", resp_valid, 1);
        chk("b2b_noar", arvalid, 0);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        chk("b2b_gap", {arvalid, req_ready}, 2'b01);
        tick;
        req_valid = 1'b0;
        serve(32'h12B0, 0, 0, -1, -1, 0, LW);
        finish_resp(128'h0000146F_0000146E_0000146D_0000146C, 1'b0, 0);

        // Reset after beat 1
        do_req(32'h200);
        serve(32'h200, 0, 0, -1, -1, 0, 2);
        rst = 1'b1;
        tick;
        chk("mid_rst", {arvalid, rready, resp_valid}, 3'b000);
        rst = 1'b0;
        tick;
        chk("mid_rst_ready", req_ready, 1);
        do_req(32'h10C);
        serve(32'h100, 0, 0, -1, -1, 0, LW);
        finish_resp(128'h00001003_00001002_00001001_00001000, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
